burst_ram: RTL and testbench

- Burst-oriented RAM model/controller directly downstream of the instruction/data cache pair.
- Consumes the cache's br_* command bus and returns read bursts with a valid strobe.
- Write bursts are applied with a per-byte mask.
- Stands in for the DDR/PSRAM burst interface in simulation and small FPGA builds, with the same handshake timing: fixed read latency, busy during init and during bursts.

---
 rtl/burst_ram.sv | 172 +++++++++++++++++
 tb/tb_burst_ram.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/burst_ram.sv
// rtl/burst_ram.sv - burst RAM behind the cache br_* bus, fixed read latency, masked write bursts
module burst_ram #(
  parameter int DATA_BITWIDTH            = 64,
  parameter int DEPTH_BITWIDTH           = 4,
  parameter int BURST_COUNT              = 4,
  parameter int CYCLES_BEFORE_DATA_VALID = 6,
  parameter int CYCLES_BEFORE_INITIATED  = 10,
  parameter     INIT_FILE                = ""
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd,
  input  logic                       cmd_en,
  input  logic [DEPTH_BITWIDTH-1:0]  addr,
  input  logic [DATA_BITWIDTH-1:0]   wr_data,
  input  logic [DATA_BITWIDTH/8-1:0] data_mask,
  output logic [DATA_BITWIDTH-1:0]   rd_data,
  output logic                       rd_data_valid,
  output logic                       busy
);

  localparam int BYTES  = DATA_BITWIDTH / 8;
  localparam int DEPTH  = 2 ** DEPTH_BITWIDTH;
  localparam int BEAT_W = (BURST_COUNT > 1) ? $clog2(BURST_COUNT) : 1;
  localparam int LAT_W  = $clog2(CYCLES_BEFORE_DATA_VALID);
  localparam int INIT_W = (CYCLES_BEFORE_INITIATED > 1) ? $clog2(CYCLES_BEFORE_INITIATED) : 1;

  // The wait state consumes one edge and the first beat is registered on another.
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(CYCLES_BEFORE_DATA_VALID - 2);
  localparam logic [INIT_W-1:0] INIT_LOAD = INIT_W'(CYCLES_BEFORE_INITIATED - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_COUNT - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_READ_WAIT,
    S_READ_BURST,
    S_WRITE_BURST
  } state_t;

  state_t                    state_q, state_d;
  logic [INIT_W-1:0]         init_cnt_q, init_cnt_d;
  logic [LAT_W-1:0]          lat_cnt_q, lat_cnt_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic [DEPTH_BITWIDTH-1:0] addr_q, addr_d;
  logic [DATA_BITWIDTH-1:0]  rd_data_q, rd_data_d;
  logic                      rd_data_valid_q, rd_data_valid_d;
  logic                      busy_q, busy_d;

  logic [DATA_BITWIDTH-1:0]  mem [DEPTH];
  logic                      wr_en;
  logic [DEPTH_BITWIDTH-1:0] wr_addr;
  logic [DEPTH_BITWIDTH-1:0] beat_addr;

  logic unused_init_file;
  assign unused_init_file = ^INIT_FILE;

  // Address arithmetic is DEPTH_BITWIDTH wide so bursts wrap past the top to 0.
  assign beat_addr = addr_q + DEPTH_BITWIDTH'(beat_q);

  always_comb begin
    state_d         = state_q;
    init_cnt_d      = init_cnt_q;
    lat_cnt_d       = lat_cnt_q;
    beat_d          = beat_q;
    addr_d          = addr_q;
    rd_data_d       = rd_data_q;
    rd_data_valid_d = rd_data_valid_q;
    busy_d          = busy_q;
    wr_en           = 1'b0;
    wr_addr         = beat_addr;

    case (state_q)
      S_INIT: begin
        if (init_cnt_q == '0) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          init_cnt_d = init_cnt_q - 1'b1;
        end
      end
      S_IDLE: begin
        if (cmd_en && !busy_q) begin
          addr_d = addr;
          busy_d = 1'b1;
          if (cmd) begin
            // Beat 0 of a write lands on the accepting edge itself.
            wr_en   = 1'b1;
            wr_addr = addr;
            beat_d  = BEAT_W'(1);
            state_d = S_WRITE_BURST;
          end else begin
            lat_cnt_d = LAT_LOAD;
            beat_d    = '0;
            state_d   = S_READ_WAIT;
          end
        end
      end
      S_WRITE_BURST: begin
        wr_en  = 1'b1;
        beat_d = beat_q + 1'b1;
        if (beat_q == LAST_BEAT) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_READ_WAIT: begin
        if (lat_cnt_q == '0) begin
          rd_data_valid_d = 1'b1;
          rd_data_d       = mem[beat_addr];
          beat_d          = beat_q + 1'b1;
          state_d         = S_READ_BURST;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      S_READ_BURST: begin
        // The beat counter wraps to 0 once the last beat has been issued.
        if (beat_q == '0) begin
          rd_data_valid_d = 1'b0;
          rd_data_d       = '0;
          busy_d          = 1'b0;
          state_d         = S_IDLE;
        end else begin
          rd_data_d = mem[beat_addr];
          beat_d    = beat_q + 1'b1;
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_INIT;
      init_cnt_q      <= INIT_LOAD;
      lat_cnt_q       <= '0;
      beat_q          <= '0;
      addr_q          <= '0;
      rd_data_q       <= '0;
      rd_data_valid_q <= 1'b0;
      busy_q          <= 1'b1;
    end else begin
      state_q         <= state_d;
      init_cnt_q      <= init_cnt_d;
      lat_cnt_q       <= lat_cnt_d;
      beat_q          <= beat_d;
      addr_q          <= addr_d;
      rd_data_q       <= rd_data_d;
      rd_data_valid_q <= rd_data_valid_d;
      busy_q          <= busy_d;
    end
  end

  // Memory has no reset; wr_en is low whenever the controller sits in INIT.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BYTES; b++) begin
        if (!data_mask[b]) begin
          mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  assign rd_data       = rd_data_q;
  assign rd_data_valid = rd_data_valid_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_burst_ram.sv
// tb/tb_burst_ram.sv - scoreboard bench for burst_ram
module tb_burst_ram;

  localparam int DW  = 64;
  localparam int AW  = 4;
  localparam int LAT = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cmd = 1'b0;
  logic          cmd_en = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [7:0]    data_mask = '0;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic          busy;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    cyc = 0;
  int    errors = 0;
  int    checks = 0;

  burst_ram dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd           (cmd),
    .cmd_en        (cmd_en),
    .addr          (addr),
    .wr_data       (wr_data),
    .data_mask     (data_mask),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .busy          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every valid beat must match the head of the scoreboard in data and cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (rd_data_valid) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected cyc=%0d got=%h required=no beat", cyc, rd_data);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          if (e.data !== rd_data || e.cyc != cyc) begin
            errors++;
            $display("FAIL beat got=%h@%0d required=%h@%0d", rd_data, cyc, e.data, e.cyc);
          end
        end
      end else if (rd_data !== '0) begin
        errors++;
        $display("FAIL rd_data_idle cyc=%0d got=%h required=0", cyc, rd_data);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (busy) check("ready_timeout", 64'(busy), 64'd0);
  endtask

  // Called at the negedge where rst_n has just risen; counts edges that see busy=1.
  task automatic count_init(input string name);
    int n = 0;
    while (busy && n < 30) begin
      n++;
      @(negedge clk);
    end
    check(name, 64'(n), 64'd10);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [4*DW-1:0] d, input logic [31:0] m);
    logic [3:0] pat = '0;
    wait_ready();
    cmd_en = 1'b1; cmd = 1'b1; addr = a;
    wr_data = d[0 +: DW]; data_mask = m[0 +: 8];
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      pat = {pat[2:0], busy};
      cmd_en = 1'b0;
      if (k < 4) begin
        wr_data = d[k*DW +: DW];
        data_mask = m[k*8 +: 8];
      end
    end
    check("wr_busy_pattern", 64'(pat), 64'b1110);
  endtask

  task automatic do_read(input string name, input logic [AW-1:0] a, input logic [4*DW-1:0] d,
                         input bit poke);
    int e_cyc;
    int n = 0;
    beat_t b;
    wait_ready();
    e_cyc = cyc + 1;
    cmd_en = 1'b1; cmd = 1'b0; addr = a;
    for (int k = 0; k < 4; k++) begin
      b.cyc = e_cyc + LAT - 1 + k;
      b.data = d[k*DW +: DW];
      exp_q.push_back(b);
    end
    @(negedge clk);
    while (busy && n < 40) begin
      n++;
      if (poke && n == 2) begin
        cmd_en = 1'b1; cmd = 1'b1; addr = '0; wr_data = '0; data_mask = '0;
      end else begin
        cmd_en = 1'b0;
      end
      @(negedge clk);
    end
    cmd_en = 1'b0;
    check(name, 64'(n), 64'd9);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1);
  end

  initial begin
    int e_cyc;
    beat_t b;

    // Reset with cmd_en held high through INIT: it must never be accepted.
    @(negedge clk);
    rst_n = 1'b0; cmd_en = 1'b1; cmd = 1'b0; addr = 4'd4;
    repeat (3) @(negedge clk);
    check("reset_valid", 64'(rd_data_valid), 64'd0);
    check("reset_rd_data", rd_data, 64'd0);
    check("reset_busy", 64'(busy), 64'd1);
    rst_n = 1'b1;
    count_init("init_busy_edges");
    cmd_en = 1'b0;
    repeat (12) @(negedge clk);
    check("init_no_beats_busy", 64'(busy), 64'd0);

    // Write at 4, then read-after-write at the earliest accept edge.
    do_write(4'd4, {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}}, 32'h0);
    do_read("rd4_busy_len", 4'd4, {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}}, 1'b0);

    // Byte mask: all-ones then low half zeroed; mask 0xFF beats leave memory alone.
    do_write(4'd0, {4{64'hFFFF_FFFF_FFFF_FFFF}}, 32'h0);
    do_write(4'd0, {{3{64'h1234_5678_9ABC_DEF0}}, 64'h0}, 32'hFFFF_FFF0);
    do_read("rd0_mask_busy_len", 4'd0,
            {{3{64'hFFFF_FFFF_FFFF_FFFF}}, 64'hFFFF_FFFF_0000_0000}, 1'b0);

    // Wrap-around write at 14 covers 14,15,0,1.
    do_write(4'd14, {{8{8'hDD}}, {8{8'hCC}}, {8{8'hBB}}, {8{8'hAA}}}, 32'h0);
    do_read("rd0_wrap_busy_len", 4'd0,
            {{2{64'hFFFF_FFFF_FFFF_FFFF}}, {8{8'hDD}}, {8{8'hCC}}}, 1'b0);
    do_read("rd14_wrap_busy_len", 4'd14,
            {{8{8'hDD}}, {8{8'hCC}}, {8{8'hBB}}, {8{8'hAA}}}, 1'b0);

    // A write command poked at T0+2 must be ignored; next read accepted at T0+10.
    do_read("rd4_poke_busy_len", 4'd4, {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}}, 1'b1);
    do_read("rd2_b2b_busy_len", 4'd2,
            {{8{8'h22}}, {8{8'h11}}, {2{64'hFFFF_FFFF_FFFF_FFFF}}}, 1'b0);

    // Reset during the second valid beat of a read.
    wait_ready();
    e_cyc = cyc + 1;
    cmd_en = 1'b1; cmd = 1'b0; addr = 4'd4;
    b.cyc = e_cyc + LAT - 1; b.data = {8{8'h11}}; exp_q.push_back(b);
    b.cyc = e_cyc + LAT;     b.data = {8{8'h22}}; exp_q.push_back(b);
    @(negedge clk);
    cmd_en = 1'b0;
    repeat (6) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrd_reset_valid", 64'(rd_data_valid), 64'd0);
    check("midrd_reset_rd_data", rd_data, 64'd0);
    check("midrd_reset_busy", 64'(busy), 64'd1);
    check("midrd_beats_left", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_init("reinit_busy_edges");
    do_read("rd4_after_reset_busy_len", 4'd4,
            {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}}, 1'b0);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
